// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and hazard-cause encoding for the pipeline stall/flush controller.
package hazard_ctrl_pkg;

  localparam int unsigned DEF_REGW    = 5;
  localparam int unsigned DEF_MUL_LAT = 4;
  localparam int unsigned DEF_DIV_LAT = 32;
  localparam int unsigned DEF_CNTW    = 32;

  typedef enum logic [2:0] {
    CauseNone,
    CauseMemWait,
    CauseMdStruct,
    CauseBranch,
    CauseLoadUse,
    CauseHilo
  } cause_e;

  // Counter width able to hold the longest mul/div latency.
  function automatic int unsigned md_cnt_width(input int unsigned max_lat);
    return $clog2(max_lat + 1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_counter.sv
// Tracks how long the multi-cycle mul/div unit stays busy after an op leaves EX.
module hazard_ctrl_md_busy_counter
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = DEF_MUL_LAT,
  parameter int unsigned DIV_LAT = DEF_DIV_LAT
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic is_div,
  output logic busy
);

  localparam int unsigned CW = md_cnt_width(DIV_LAT);

  logic [CW-1:0] cnt_q, cnt_d;

  // A new op reloads even while the previous one is still counting down.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: one priority mux over the
// hazard causes, the mul/div busy tracker and a stall-cycle performance counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REGW    = DEF_REGW,
  parameter int unsigned MUL_LAT = DEF_MUL_LAT,
  parameter int unsigned DIV_LAT = DEF_DIV_LAT,
  parameter int unsigned CNTW    = DEF_CNTW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            id_uses_rt,
  input  logic            id_reads_hilo,
  input  logic            ex_memread,
  input  logic [REGW-1:0] ex_rt,
  input  logic            ex_branch_taken,
  input  logic            ex_md_start,
  input  logic            ex_md_is_div,
  input  logic            mem_req,
  input  logic            mem_ready,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            idex_en,
  output logic            exmem_en,
  output logic            memwb_en,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic            exmem_flush,
  output logic            memwb_flush,
  output logic            md_busy,
  output logic [CNTW-1:0] stall_cycles
);

  logic   loaduse, hilo, mdstruct, memwait;
  logic   md_load;
  cause_e cause;

  logic [CNTW-1:0] stall_q;

  assign loaduse  = ex_memread && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign hilo     = id_reads_hilo && (md_busy || ex_md_start);
  assign mdstruct = ex_md_start && md_busy;
  assign memwait  = mem_req && !mem_ready;

  always_comb begin
    cause = CauseNone;
    if (memwait) begin
      cause = CauseMemWait;
    end else if (mdstruct) begin
      cause = CauseMdStruct;
    end else if (ex_branch_taken) begin
      cause = CauseBranch;
    end else if (loaduse) begin
      cause = CauseLoadUse;
    end else if (hilo) begin
      cause = CauseHilo;
    end
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    if (reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else begin
      unique case (cause)
        // Freeze up to EX/MEM so a taken branch waits in EX until memory completes.
        CauseMemWait: begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_en    = 1'b0;
          memwb_flush = 1'b1;
        end
        CauseMdStruct: begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_flush = 1'b1;
        end
        CauseBranch: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end
        CauseLoadUse, CauseHilo: begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Only an op that actually advances into MEM starts the busy window.
  assign md_load = ex_md_start && exmem_en && !exmem_flush;

  hazard_ctrl_md_busy_counter #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_busy_counter (
    .clk    (clk),
    .reset  (reset),
    .load   (md_load),
    .is_div (ex_md_is_div),
    .busy   (md_busy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (!pc_en) begin
      stall_q <= stall_q + CNTW'(1);
    end
  end

  assign stall_cycles = stall_q;

endmodule
